controlador_teclado: RTL and testbench

- Receiver/controller for the 5-bit keypad interface (`teclas` code + `valido` strobe). Codes arrive asynchronously, bounce, and are X while `valido`=0.
- The block synchronizes the inputs, debounces press and release, and captures exactly one code per key press.
- Captured codes are queued in a small FIFO. A downstream consumer drains it through a first-word-fall-through read handshake.
- Sits between the keypad model/pins and any consumer logic (decoder, display, CPU port).

---
 rtl/teclado_pkg.sv | 14 +
 rtl/fifo_teclas.sv | 62 ++++++
 rtl/controlador_teclado.sv | 137 +++++++++++++
 tb/tb_controlador_teclado.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad controller: debounce FSM states and
// the default key-code width.
package teclado_pkg;

  localparam int ANCHO_DEF = 5;

  typedef enum logic [1:0] {
    ESPERA        = 2'd0,
    ESTABILIZANDO = 2'd1,
    PRESIONADA    = 2'd2,
    LIBERANDO     = 2'd3
  } estado_t;

endpackage

// File: rtl/fifo_teclas.sv
// Small first-word-fall-through FIFO for captured key codes. A push into a
// full FIFO is dropped (and flagged) unless a pop frees a slot in the same
// cycle. A pop request while empty is ignored.
module fifo_teclas
  import teclado_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int PROF  = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic [ANCHO-1:0] din,
  input  logic             pop,
  output logic [ANCHO-1:0] dout,
  output logic             vacio,
  output logic             lleno,
  output logic             drop
);

  localparam int PW = $clog2(PROF);
  localparam int CW = PW + 1;

  logic [ANCHO-1:0] mem [PROF];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign vacio   = (count == '0);
  assign lleno   = (count == CW'(PROF));
  assign do_pop  = pop && !vacio;
  assign do_push = push && (!lleno || do_pop);
  assign drop    = push && lleno && !do_pop;
  assign dout    = vacio ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the memory array has no reset; only the pointers and count define
  // which entries are valid, and dout is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally since PROF is a power of two.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/controlador_teclado.sv
// Keypad receiver: synchronizes the raw code/strobe, debounces press and
// release, captures one code per press and queues it for the consumer.
module controlador_teclado
  import teclado_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int DEB   = 4,
  parameter int PROF  = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [ANCHO-1:0] teclas,
  input  logic             valido,
  input  logic             leer,
  input  logic             borrar_ovf,
  output logic [ANCHO-1:0] dato_out,
  output logic             dato_valido,
  output logic             lleno,
  output logic             overflow,
  output logic [1:0]       estado
);

  localparam logic [3:0] CNT_FIN = 4'(DEB - 1);

  logic             valido_q1, valido_s;
  logic [ANCHO-1:0] teclas_q1, teclas_s;
  estado_t          state, state_nxt;
  logic [ANCHO-1:0] cod, cod_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             push;
  logic             drop;
  logic             vacio;

  // Two-flop synchronizer on the strobe and on every code bit.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value, which is what makes the chain two stages deep.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valido_q1 <= 1'b0;
      valido_s  <= 1'b0;
      teclas_q1 <= '0;
      teclas_s  <= '0;
    end else begin
      valido_q1 <= valido;
      valido_s  <= valido_q1;
      teclas_q1 <= teclas;
      teclas_s  <= teclas_q1;
    end
  end

  // Debounce FSM state, captured code and stability counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= ESPERA;
      cod   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cod   <= cod_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; teclas_s is only looked at while valido_s is high.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cod_nxt   = cod;
    cnt_nxt   = cnt;
    push      = 1'b0;
    case (state)
      ESPERA: begin
        if (valido_s) begin
          state_nxt = ESTABILIZANDO;
          cod_nxt   = teclas_s;
          cnt_nxt   = 4'd1;
        end
      end
      ESTABILIZANDO: begin
        if (!valido_s) begin
          state_nxt = ESPERA;
        end else if (teclas_s != cod) begin
          cod_nxt = teclas_s;
          cnt_nxt = 4'd1;
        end else if (cnt == CNT_FIN) begin
          state_nxt = PRESIONADA;
          push      = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      PRESIONADA: begin
        if (!valido_s) begin
          state_nxt = LIBERANDO;
          cnt_nxt   = 4'd1;
        end
      end
      LIBERANDO: begin
        if (valido_s) begin
          state_nxt = PRESIONADA;
        end else if (cnt == CNT_FIN) begin
          state_nxt = ESPERA;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = ESPERA;
    endcase
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)        overflow <= 1'b0;
    else if (drop)       overflow <= 1'b1;
    else if (borrar_ovf) overflow <= 1'b0;
  end

  fifo_teclas #(
    .ANCHO (ANCHO),
    .PROF  (PROF)
  ) u_fifo (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push),
    .din     (cod),
    .pop     (leer),
    .dout    (dato_out),
    .vacio   (vacio),
    .lleno   (lleno),
    .drop    (drop)
  );

  assign dato_valido = !vacio;
  assign estado      = state;

endmodule

// File: tb/tb_controlador_teclado.sv
// Directed bench for the keypad controller (ANCHO=5, DEB=4, PROF=4).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_controlador_teclado;

  logic       clk;
  logic       reset_L;
  logic [4:0] teclas;
  logic       valido;
  logic       leer;
  logic       borrar_ovf;
  logic [4:0] dato_out;
  logic       dato_valido;
  logic       lleno;
  logic       overflow;
  logic [1:0] estado;

  int n_pass  = 0;
  int n_total = 0;

  controlador_teclado #(
    .ANCHO (5),
    .DEB   (4),
    .PROF  (4)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .teclas      (teclas),
    .valido      (valido),
    .leer        (leer),
    .borrar_ovf  (borrar_ovf),
    .dato_out    (dato_out),
    .dato_valido (dato_valido),
    .lleno       (lleno),
    .overflow    (overflow),
    .estado      (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full press: held 10 cycles, released 12 cycles (push happens inside).
  task automatic press(input logic [4:0] code);
    valido = 1'b1;
    teclas = code;
    cycles(10);
    valido = 1'b0;
    teclas = 'x;
    cycles(12);
  endtask

  task automatic pop_one;
    leer = 1'b1;
    cycles(1);
    leer = 1'b0;
  endtask

  initial begin
    reset_L    = 1'b0;
    teclas     = '0;
    valido     = 1'b0;
    leer       = 1'b0;
    borrar_ovf = 1'b0;
    cycles(2);
    check("rst_dato_out", dato_out, 0);
    check("rst_dato_valido", dato_valido, 0);
    check("rst_lleno", lleno, 0);
    check("rst_overflow", overflow, 0);
    check("rst_estado", estado, 0);
    reset_L = 1'b1;
    cycles(2);

    // Clean press: write lands on the 6th edge after inputs settle.
    valido = 1'b1;
    teclas = 5'b10110;
    cycles(3);
    check("clean_estab", estado, 1);
    cycles(2);
    check("clean_no_push_e5", dato_valido, 0);
    cycles(1);
    check("clean_valido_e6", dato_valido, 1);
    check("clean_dato_e6", dato_out, 5'b10110);
    check("clean_presionada", estado, 2);
    cycles(14);
    valido = 1'b0;
    teclas = 'x;
    cycles(3);
    check("clean_liberando", estado, 3);
    cycles(3);
    check("clean_espera", estado, 0);
    cycles(14);
    check("clean_head", dato_out, 5'b10110);
    pop_one();
    check("clean_single_push", dato_valido, 0);
    check("clean_empty_dout", dato_out, 0);

    // Press bounce: 2 high, 1 low, 2 high, 1 low, then stable.
    valido = 1'b1; teclas = 5'b00011; cycles(2);
    valido = 1'b0; teclas = 'x;       cycles(1);
    valido = 1'b1; teclas = 5'b00011; cycles(2);
    valido = 1'b0; teclas = 'x;       cycles(1);
    valido = 1'b1; teclas = 5'b00011;
    cycles(5);
    check("bounce_no_push", dato_valido, 0);
    cycles(1);
    check("bounce_push", dato_valido, 1);
    check("bounce_code", dato_out, 5'b00011);
    cycles(10);
    valido = 1'b0; teclas = 'x;
    cycles(12);
    pop_one();
    check("bounce_single", dato_valido, 0);

    // Code glitch: first code seen for 2 cycles, then a different stable code.
    valido = 1'b1; teclas = 5'b00101;
    cycles(2);
    teclas = 5'b01000;
    cycles(5);
    check("glitch_no_push", dato_valido, 0);
    cycles(1);
    check("glitch_push", dato_valido, 1);
    check("glitch_code", dato_out, 5'b01000);

    // Release bounce while held, then code change while held.
    cycles(5);
    valido = 1'b0; teclas = 'x;
    cycles(2);
    valido = 1'b1; teclas = 5'b01000;
    cycles(1);
    check("relb_liberando", estado, 3);
    cycles(2);
    check("relb_back_pres", estado, 2);
    teclas = 5'b11111;
    cycles(10);
    check("held_change_estado", estado, 2);
    pop_one();
    check("held_no_second_push", dato_valido, 0);
    valido = 1'b0; teclas = 'x;
    cycles(12);
    check("held_release_espera", estado, 0);

    // Overflow: five presses, no reads.
    press(5'd1);
    press(5'd2);
    press(5'd3);
    check("ovf_not_full_3", lleno, 0);
    press(5'd4);
    check("ovf_full_4", lleno, 1);
    check("ovf_clear_4", overflow, 0);
    press(5'd5);
    check("ovf_set_5", overflow, 1);
    check("ovf_still_full", lleno, 1);
    check("ovf_pop1", dato_out, 5'd1); pop_one();
    check("ovf_pop2", dato_out, 5'd2); pop_one();
    check("ovf_pop3", dato_out, 5'd3); pop_one();
    check("ovf_pop4", dato_out, 5'd4); pop_one();
    check("ovf_drained", dato_valido, 0);
    check("ovf_sticky", overflow, 1);
    borrar_ovf = 1'b1; cycles(1); borrar_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Push and pop in the same cycle while full.
    press(5'd6);
    press(5'd7);
    press(5'd8);
    press(5'd9);
    check("sim_full", lleno, 1);
    valido = 1'b1; teclas = 5'd10;
    cycles(5);
    leer = 1'b1;
    cycles(1);
    leer = 1'b0;
    check("sim_count_full", lleno, 1);
    check("sim_no_ovf", overflow, 0);
    check("sim_head", dato_out, 5'd7);
    cycles(4);
    valido = 1'b0; teclas = 'x;
    cycles(12);

    // Drop and clear in the same cycle: set wins.
    valido = 1'b1; teclas = 5'd11;
    cycles(5);
    borrar_ovf = 1'b1;
    cycles(1);
    borrar_ovf = 1'b0;
    check("setwins_ovf", overflow, 1);
    cycles(4);
    valido = 1'b0; teclas = 'x;
    cycles(12);
    borrar_ovf = 1'b1; cycles(1); borrar_ovf = 1'b0;
    check("setwins_cleared", overflow, 0);

    check("drain_7", dato_out, 5'd7);  pop_one();
    check("drain_8", dato_out, 5'd8);  pop_one();
    check("drain_9", dato_out, 5'd9);  pop_one();
    check("drain_10", dato_out, 5'd10); pop_one();
    pop_one();
    check("empty_read_valido", dato_valido, 0);
    check("empty_read_dout", dato_out, 0);
    check("empty_read_lleno", lleno, 0);
    press(5'd12);
    check("after_empty_read", dato_out, 5'd12);

    // Asynchronous reset in the middle of ESTABILIZANDO.
    valido = 1'b1; teclas = 5'd3;
    cycles(3);
    check("rst_mid_estab", estado, 1);
    check("rst_mid_pending", dato_valido, 1);
    #2 reset_L = 1'b0;
    #1;
    check("arst_dato_out", dato_out, 0);
    check("arst_dato_valido", dato_valido, 0);
    check("arst_lleno", lleno, 0);
    check("arst_estado", estado, 0);
    @(negedge clk);
    reset_L = 1'b1;
    cycles(5);
    check("rerun_no_push", dato_valido, 0);
    cycles(1);
    check("rerun_push", dato_valido, 1);
    check("rerun_code", dato_out, 5'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
